// File: rtl/writeback.sv
// Cache-line write-back unit: reads one line from the cache data array and streams it to main memory.
// Optional build macro WRITEBACK_DIRTY_MASK_EN adds a per-word dirty_mask that gates main_mem_we.
module writeback #(
  parameter int LINE_LOG2 = 3,
  parameter int INDEX_W   = 6,
  parameter int MEM_AW    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  addr,
  input  logic                         start,
`ifdef WRITEBACK_DIRTY_MASK_EN
  input  logic [(1<<LINE_LOG2)-1:0]    dirty_mask,
`endif
  output logic [INDEX_W+LINE_LOG2-1:0] cache_data_addr,
  input  logic [31:0]                  cache_data,
  output logic [MEM_AW-1:0]            main_mem_addr,
  output logic [31:0]                  main_mem_data,
  output logic                         main_mem_we,
  output logic                         busy,
  output logic                         done
);

  localparam int WORDS = 1 << LINE_LOG2;
  localparam int CA_W  = INDEX_W + LINE_LOG2;
  localparam int HI    = (INDEX_W + 4 > 11) ? INDEX_W + 4 : 11;
  localparam logic [LINE_LOG2-1:0] LAST = LINE_LOG2'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t               state;
  logic [LINE_LOG2-1:0] cnt;
  logic [HI:5]          addr_lat;
  logic [LINE_LOG2-1:0] cnt_inc;
  logic [LINE_LOG2-1:0] cnt_inc2;
  logic                 we_first;
  logic                 we_next;
  logic                 addr_unused;

  assign addr_unused = ^{addr[31:HI+1], addr[4:0]};
  assign cnt_inc     = cnt + LINE_LOG2'(1);
  assign cnt_inc2    = cnt + LINE_LOG2'(2);

`ifdef WRITEBACK_DIRTY_MASK_EN
  logic [WORDS-1:0] mask_lat;
  assign we_first = mask_lat[cnt];
  assign we_next  = mask_lat[cnt_inc];
`else
  assign we_first = 1'b1;
  assign we_next  = 1'b1;
`endif

  function automatic logic [CA_W-1:0] cache_addr_of(input logic [INDEX_W+4:5] a,
                                                     input logic [LINE_LOG2-1:0] w);
    return {a[INDEX_W+4:5], w};
  endfunction

  function automatic logic [MEM_AW-1:0] mem_addr_of(input logic [11:5] a,
                                                    input logic [LINE_LOG2-1:0] w);
    return MEM_AW'({a[11:5], w});
  endfunction

  // Only WRITE cycles carry data; elsewhere the write bus idles at zero.
  assign main_mem_data = (state == WRITE) ? cache_data : 32'd0;

  // All outputs are registered one edge ahead so each cycle presents its own addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_lat        <= '0;
      cache_data_addr <= '0;
      main_mem_addr   <= '0;
      main_mem_we     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef WRITEBACK_DIRTY_MASK_EN
      mask_lat        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state           <= READ;
            addr_lat        <= addr[HI:5];
            cnt             <= '0;
            cache_data_addr <= cache_addr_of(addr[INDEX_W+4:5], '0);
            main_mem_addr   <= '0;
            main_mem_we     <= 1'b0;
            busy            <= 1'b1;
`ifdef WRITEBACK_DIRTY_MASK_EN
            mask_lat        <= dirty_mask;
`endif
          end
        end
        READ: begin
          state           <= WRITE;
          main_mem_we     <= we_first;
          main_mem_addr   <= mem_addr_of(addr_lat[11:5], cnt);
          cache_data_addr <= cache_addr_of(addr_lat[INDEX_W+4:5], cnt_inc);
        end
        WRITE: begin
          if (cnt == LAST) begin
            state           <= DONE;
            cnt             <= '0;
            main_mem_we     <= 1'b0;
            main_mem_addr   <= '0;
            cache_data_addr <= '0;
            busy            <= 1'b0;
            done            <= 1'b1;
          end else begin
            cnt           <= cnt_inc;
            main_mem_we   <= we_next;
            main_mem_addr <= mem_addr_of(addr_lat[11:5], cnt_inc);
            // Prefetch runs one word ahead; nothing left to fetch for the final word.
            cache_data_addr <= (cnt_inc == LAST) ? '0
                                                 : cache_addr_of(addr_lat[INDEX_W+4:5], cnt_inc2);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          cnt             <= '0;
          main_mem_we     <= 1'b0;
          main_mem_addr   <= '0;
          cache_data_addr <= '0;
          busy            <= 1'b0;
          done            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: each accepted start pushes the expected 10-cycle output trace.
// Build with WRITEBACK_DIRTY_MASK_EN defined to exercise the dirty-mask variant as well.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        start = 1'b0;
  logic [8:0]  cache_data_addr;
  logic [31:0] cache_data = 32'd0;
  logic [9:0]  main_mem_addr;
  logic [31:0] main_mem_data;
  logic        main_mem_we;
  logic        busy;
  logic        done;
`ifdef WRITEBACK_DIRTY_MASK_EN
  logic [7:0]  dirty_mask = 8'hFF;
`endif

  writeback dut (
    .clk             (clk),
    .rst             (rst),
    .addr            (addr),
    .start           (start),
`ifdef WRITEBACK_DIRTY_MASK_EN
    .dirty_mask      (dirty_mask),
`endif
    .cache_data_addr (cache_data_addr),
    .cache_data      (cache_data),
    .main_mem_addr   (main_mem_addr),
    .main_mem_data   (main_mem_data),
    .main_mem_we     (main_mem_we),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  cda;
    logic [9:0]  mma;
    logic [31:0] mmd;
    logic        chk_data;
    logic        we;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] main_mem [0:1023];

  function automatic logic [31:0] cache_word(input logic [8:0] a);
    if (a[8:3] == 6'h12) return 32'hC0DE_0000 + {29'd0, a[2:0]};
    return 32'h5A00_0000 + {23'd0, a};
  endfunction

  // Synchronous-read cache array and single-cycle main-memory write port.
  always @(posedge clk) cache_data <= cache_word(cache_data_addr);
  always @(posedge clk) if (main_mem_we) main_mem[main_mem_addr] <= main_mem_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] a, input logic [7:0] m);
    exp_t e;
    logic [5:0] idx;
    logic [6:0] mb;
    idx = a[10:5];
    mb  = a[11:5];
    $display("start accepted: addr=%h mask=%b", a, m);
    e = '{cda: {idx, 3'd0}, mma: 10'd0, mmd: 32'd0, chk_data: 1'b0, we: 1'b0, busy: 1'b1, done: 1'b0};
    q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      e.cda      = (k < 7) ? {idx, 3'(k + 1)} : 9'd0;
      e.mma      = {mb, 3'(k)};
      e.mmd      = cache_word({idx, 3'(k)});
      e.chk_data = 1'b1;
      e.we       = m[k];
      e.busy     = 1'b1;
      e.done     = 1'b0;
      q.push_back(e);
    end
    e = '{cda: 9'd0, mma: 10'd0, mmd: 32'd0, chk_data: 1'b0, we: 1'b0, busy: 1'b0, done: 1'b1};
    q.push_back(e);
  endtask

  // Compare the current cycle, then drive inputs sampled at the next rising edge.
  task automatic cycle(input logic s, input logic [31:0] a, input logic [7:0] m);
    exp_t e;
    bit   idle;
    logic [7:0] mask_eff;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      idle = 1'b0;
    end else begin
      e = '{cda: 9'd0, mma: 10'd0, mmd: 32'd0, chk_data: 1'b0, we: 1'b0, busy: 1'b0, done: 1'b0};
      idle = 1'b1;
    end
    check("cache_data_addr", 32'(cache_data_addr), 32'(e.cda));
    check("main_mem_addr", 32'(main_mem_addr), 32'(e.mma));
    check("main_mem_we", 32'(main_mem_we), 32'(e.we));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    if (e.chk_data) check("main_mem_data", main_mem_data, e.mmd);
    start = s;
    addr  = a;
`ifdef WRITEBACK_DIRTY_MASK_EN
    dirty_mask = m;
    mask_eff   = m;
`else
    mask_eff   = 8'hFF | m;
`endif
    @(posedge clk);
    if (idle && s) push_line(a, mask_eff);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, 32'd0, 8'hFF);
    check("queue_drained", 32'(q.size()), 32'd0);
    cycle(1'b0, 32'd0, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) main_mem[i] = 32'd0;
    #1;
    check("reset_we", 32'(main_mem_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cda", 32'(cache_data_addr), 32'd0);
    check("reset_mma", 32'(main_mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 32'd0, 8'hFF);

    // Basic line write-back.
    cycle(1'b1, 32'h0000_0A40, 8'hFF);
    drain();
    for (int k = 0; k < 8; k++)
      check("mem_word", main_mem[10'h290 + 10'(k)], 32'hC0DE_0000 + 32'(k));

    // Start held high for 25 cycles: back-to-back write-backs.
    for (int i = 0; i < 25; i++) cycle(1'b1, 32'h0000_1360, 8'hFF);
    drain();

    // Start pulse with a new addr during WRITE is ignored.
    cycle(1'b1, 32'h0000_0A40, 8'hFF);
    for (int i = 1; i < 4; i++) cycle(1'b0, 32'h0000_0A40, 8'hFF);
    cycle(1'b1, 32'h0000_0000, 8'hFF);
    drain();

    // Asynchronous reset in the middle of WRITE.
    cycle(1'b1, 32'h0000_0A40, 8'hFF);
    for (int i = 1; i < 5; i++) cycle(1'b0, 32'h0000_0A40, 8'hFF);
    #2 rst = 1'b0;
    #1;
    check("midrst_we", 32'(main_mem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_cda", 32'(cache_data_addr), 32'd0);
    check("midrst_mma", 32'(main_mem_addr), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    check("inrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cycle(1'b0, 32'd0, 8'hFF);
    cycle(1'b1, 32'h0000_0A40, 8'hFF);
    drain();

    // Top index and memory-address truncation.
    cycle(1'b1, 32'hFFFF_FFE0, 8'hFF);
    drain();

`ifdef WRITEBACK_DIRTY_MASK_EN
    cycle(1'b1, 32'h0000_0A40, 8'b1010_0101);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
